sector_addr_uart_tx: RTL and testbench

//  Serialises the current sector address as a UART frame whenever the address changes, or on request.

---
 rtl/sector_addr_uart_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_sector_addr_uart_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sector_addr_uart_tx.sv
// sector_addr_uart_tx
// Sends the current sector address as a UART frame whenever the address
// changes, or when force_send pulses. Frame layout: START, ADDR_W data bits
// (optionally Gray-encoded, MSB- or LSB-first), optional parity, 1-2 STOP bits.
// Bit timing comes from a clock-enable style counter in the clk domain.
//
// Request semantics: a request ("trig") is a single-cycle event, either an
// addr_in change against the previous cycle's value or a force_send pulse.
// There is no back-pressure. A request seen in IDLE starts a frame on the
// next edge. A request seen while a frame is in flight goes into a one-deep
// pending slot, where the latest value wins. Overwriting an occupied slot
// pulses overrun.
module sector_addr_uart_tx #(
  parameter int ADDR_W    = 4,
  parameter int BAUD_DIV  = 480,
  parameter int GRAY_EN   = 1,
  parameter int MSB_FIRST = 1,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              force_send,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic [2:0]        state_dbg
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W = $clog2(ADDR_W) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(ADDR_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  baud_cnt, cnt_nxt;
  logic [IDX_W-1:0]  bit_idx, idx_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] shreg, shreg_nxt;
  logic [ADDR_W-1:0] pend_val, pend_val_nxt;
  logic              pending, pend_nxt;
  logic              ovr_nxt;
  logic              trig;
  logic              bit_end;
  logic [ADDR_W-1:0] enc_in;
  logic [ADDR_W-1:0] ordered;
  logic              data_bit;
  logic              par_bit;
  logic              tx_nxt;
  logic              done_nxt;

  // Payload encoding: binary-to-Gray or pass-through.
  function automatic logic [ADDR_W-1:0] enc(input logic [ADDR_W-1:0] v);
    if (GRAY_EN != 0) return v ^ (v >> 1);
    else              return v;
  endfunction

  assign trig      = (addr_in != addr_q) | force_send;
  assign enc_in    = enc(addr_in);
  assign bit_end   = (baud_cnt == CNT_LAST);
  assign state_dbg = state;

  // Next-state, counter and pending-slot logic.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = baud_cnt;
    idx_nxt      = bit_idx;
    shreg_nxt    = shreg;
    pend_nxt     = pending;
    pend_val_nxt = pend_val;
    ovr_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        // A fresh request beats a stale pending one and clears it.
        if (trig) begin
          shreg_nxt = enc_in;
          pend_nxt  = 1'b0;
          state_nxt = S_START;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else if (pending) begin
          shreg_nxt = pend_val;
          pend_nxt  = 1'b0;
          state_nxt = S_START;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt = S_DATA;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == IDX_LAST_DATA) begin
            state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            idx_nxt   = '0;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_nxt = S_STOP;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == IDX_LAST_STOP) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
    // Requests arriving mid-frame, including on the final STOP cycle, are parked.
    if ((state != S_IDLE) && trig) begin
      pend_nxt     = 1'b1;
      pend_val_nxt = enc_in;
      ovr_nxt      = pending;
    end
  end

  // Put the payload in transmit order so bit_idx always selects the next bit.
  always_comb begin
    ordered = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      ordered[i] = (MSB_FIRST != 0) ? shreg_nxt[ADDR_W-1-i] : shreg_nxt[i];
    end
  end

  // Pick the data bit that idx_nxt points at.
  always_comb begin
    data_bit = 1'b1;
    for (int i = 0; i < ADDR_W; i++) begin
      if (idx_nxt == IDX_W'(i)) data_bit = ordered[i];
    end
  end

  // Parity over the encoded payload: even -> xor, odd -> xnor.
  assign par_bit = (PARITY == 1) ? (^shreg_nxt) : (~^shreg_nxt);

  // Line level for the upcoming cycle, so tx_out can be a plain register.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = data_bit;
      S_PARITY: tx_nxt = par_bit;
      default:  tx_nxt = 1'b1;
    endcase
  end

  // frame_done lines up with the final cycle of the last STOP bit.
  assign done_nxt = (state_nxt == S_STOP) && (cnt_nxt == CNT_LAST) &&
                    (idx_nxt == IDX_LAST_STOP);

  // FSM, counters, payload and pending slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      addr_q   <= '0;
      shreg    <= '0;
      pend_val <= '0;
      pending  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= cnt_nxt;
      bit_idx  <= idx_nxt;
      addr_q   <= addr_in;
      shreg    <= shreg_nxt;
      pend_val <= pend_val_nxt;
      pending  <= pend_nxt;
    end
  end

  // Registered outputs; reset parks the line high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      tx_out     <= tx_nxt;
      busy       <= (state_nxt != S_IDLE);
      frame_done <= done_nxt;
      overrun    <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_sector_addr_uart_tx.sv
// tb_sector_addr_uart_tx
// Directed bench for sector_addr_uart_tx with BAUD_DIV=4. It uses three
// instances: the default frame format, even parity, and 8-bit LSB-first with
// odd parity. Captured frames are packed so that the first bit sent is the
// most significant bit. Literals therefore read in line order.
`timescale 1ns/1ps
module tb_sector_addr_uart_tx;

  localparam int BD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [3:0] addr_a, addr_b;
  logic [7:0] addr_c;
  logic       force_a, force_b, force_c;
  logic       tx_a, busy_a, done_a, ovr_a;
  logic       tx_b, busy_b, done_b, ovr_b;
  logic       tx_c, busy_c, done_c, ovr_c;
  logic [2:0] st_a, st_b, st_c;

  sector_addr_uart_tx #(.ADDR_W(4), .BAUD_DIV(BD)) dut_a (
    .clk(clk), .rst(rst_n), .addr_in(addr_a), .force_send(force_a),
    .tx_out(tx_a), .busy(busy_a), .frame_done(done_a), .overrun(ovr_a),
    .state_dbg(st_a));

  sector_addr_uart_tx #(.ADDR_W(4), .BAUD_DIV(BD), .PARITY(1)) dut_b (
    .clk(clk), .rst(rst_n), .addr_in(addr_b), .force_send(force_b),
    .tx_out(tx_b), .busy(busy_b), .frame_done(done_b), .overrun(ovr_b),
    .state_dbg(st_b));

  sector_addr_uart_tx #(.ADDR_W(8), .BAUD_DIV(BD), .MSB_FIRST(0), .PARITY(2)) dut_c (
    .clk(clk), .rst(rst_n), .addr_in(addr_c), .force_send(force_c),
    .tx_out(tx_c), .busy(busy_c), .frame_done(done_c), .overrun(ovr_c),
    .state_dbg(st_c));

  // Selects which instance the capture task watches.
  int   sel;
  logic tx_m, busy_m, done_m;
  always_comb begin
    case (sel)
      1:       begin tx_m = tx_b; busy_m = busy_b; done_m = done_b; end
      2:       begin tx_m = tx_c; busy_m = busy_c; done_m = done_c; end
      default: begin tx_m = tx_a; busy_m = busy_a; done_m = done_a; end
    endcase
  end

  // Overrun pulse counter for instance A.
  int ovr_cnt_a = 0;
  always @(negedge clk) if (ovr_a) ovr_cnt_a++;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver / monitor tasks ----------------
  // Call this on a negedge. It waits for busy (bounded), then samples nbits
  // bit periods of BD cycles each and returns on the negedge after the frame.
  task automatic capture(input int nbits, output logic [31:0] bits, output int wait_n,
                         output int busy_n, output int done_n, output int glitch_n);
    logic first;
    bits = '0; wait_n = 0; busy_n = 0; done_n = 0; glitch_n = 0; first = 1'b0;
    while (!busy_m && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    if (!busy_m) begin
      check_val("start_timeout", 32'(wait_n), 32'd0);
      return;
    end
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < BD; c++) begin
        if (c == 0) begin
          first = tx_m;
          bits  = (bits << 1) | 32'(tx_m);
        end else if (tx_m !== first) begin
          glitch_n++;
        end
        if (busy_m) busy_n++;
        if (done_m) done_n++;
        @(negedge clk);
      end
    end
  endtask

  // Counts cycles with busy high over a window on the watched instance.
  task automatic quiet(input int n, output int busy_seen);
    busy_seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy_m) busy_seen++;
    end
  endtask

  task automatic pulse_force_a();
    force_a = 1'b1;
    @(negedge clk);
    force_a = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] bits;
    int wait_n, busy_n, done_n, glitch_n, busy_seen, ovr_base;

    sel = 0;
    rst_n = 1'b0;
    addr_a = '0; addr_b = '0; addr_c = '0;
    force_a = 1'b0; force_b = 1'b0; force_c = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_tx_a",   32'(tx_a),   32'd1);
    check_val("rst_busy_a", 32'(busy_a), 32'd0);
    check_val("rst_done_a", 32'(done_a), 32'd0);
    check_val("rst_ovr_a",  32'(ovr_a),  32'd0);
    check_val("rst_st_a",   32'(st_a),   32'd0);
    check_val("rst_idle_bc", 32'({tx_b, busy_b, ovr_b, tx_c, busy_c, ovr_c, st_b, st_c}),
              32'b100100_000_000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 0->5, Gray 0111, MSB first
    addr_a = 4'd5;
    capture(6, bits, wait_n, busy_n, done_n, glitch_n);
    check_val("t1_latency", 32'(wait_n), 32'd1);
    check_val("t1_bits",    bits, 32'b001111);
    check_val("t1_busy",    32'(busy_n), 32'd24);
    check_val("t1_done",    32'(done_n), 32'd1);
    check_val("t1_glitch",  32'(glitch_n), 32'd0);
    check_val("t1_busy_after", 32'(busy_a), 32'd0);
    check_val("t1_tx_after",   32'(tx_a),   32'd1);

    // 3: frame for 6 (Gray 0101); 3 then 9 arrive mid-frame
    ovr_base = ovr_cnt_a;
    addr_a = 4'd6;
    fork
      capture(6, bits, wait_n, busy_n, done_n, glitch_n);
      begin
        repeat (5) @(negedge clk);
        addr_a = 4'd3;
        repeat (3) @(negedge clk);
        addr_a = 4'd9;
      end
    join
    check_val("t3_bits_6",  bits, 32'b001011);
    check_val("t3_done_6",  32'(done_n), 32'd1);
    check_val("t3_overrun", 32'(ovr_cnt_a - ovr_base), 32'd1);
    check_val("t3_gap_idle", 32'(busy_a), 32'd0);
    capture(6, bits, wait_n, busy_n, done_n, glitch_n);
    check_val("t3_gap",     32'(wait_n), 32'd1);
    check_val("t3_bits_9",  bits, 32'b011011);
    check_val("t3_busy_9",  32'(busy_n), 32'd24);
    quiet(40, busy_seen);
    check_val("t3_no_third", 32'(busy_seen), 32'd0);

    // 4: addr to 5, then stable, then force_send
    addr_a = 4'd5;
    capture(6, bits, wait_n, busy_n, done_n, glitch_n);
    check_val("t4_bits_chg", bits, 32'b001111);
    quiet(30, busy_seen);
    check_val("t4_stable_quiet", 32'(busy_seen), 32'd0);
    fork
      capture(6, bits, wait_n, busy_n, done_n, glitch_n);
      pulse_force_a();
    join
    check_val("t4_force_lat",  32'(wait_n), 32'd1);
    check_val("t4_force_bits", bits, 32'b001111);
    check_val("t4_force_busy", 32'(busy_n), 32'd24);
    check_val("t4_force_done", 32'(done_n), 32'd1);
    quiet(20, busy_seen);
    check_val("t4_force_once", 32'(busy_seen), 32'd0);

    // 5: reset in the middle of DATA
    pulse_force_a();
    repeat (6) @(negedge clk);
    check_val("t5_in_data", 32'(st_a), 32'd2);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_tx",   32'(tx_a),   32'd1);
    check_val("t5_rst_busy", 32'(busy_a), 32'd0);
    check_val("t5_rst_st",   32'(st_a),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    capture(6, bits, wait_n, busy_n, done_n, glitch_n);
    check_val("t5_lat",  32'(wait_n), 32'd1);
    check_val("t5_bits", bits, 32'b001111);
    check_val("t5_busy", 32'(busy_n), 32'd24);
    check_val("t5_done", 32'(done_n), 32'd1);

    // 2: even parity, 0->5: data 0111, parity 1, 28 cycles
    sel = 1;
    @(negedge clk);
    addr_b = 4'd5;
    capture(7, bits, wait_n, busy_n, done_n, glitch_n);
    check_val("t2_bits",   bits, 32'b0011111);
    check_val("t2_busy",   32'(busy_n), 32'd28);
    check_val("t2_done",   32'(done_n), 32'd1);
    check_val("t2_glitch", 32'(glitch_n), 32'd0);

    // 6: 8-bit, LSB first, odd parity, 0xA5 -> Gray 0xF7
    sel = 2;
    @(negedge clk);
    addr_c = 8'hA5;
    capture(11, bits, wait_n, busy_n, done_n, glitch_n);
    check_val("t6_bits",   bits, 32'b01110111101);
    check_val("t6_busy",   32'(busy_n), 32'd44);
    check_val("t6_done",   32'(done_n), 32'd1);
    check_val("t6_glitch", 32'(glitch_n), 32'd0);
    check_val("t6_idle_tx", 32'(tx_c), 32'd1);

    exp_q.delete();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
